cordic_arbiter: RTL and testbench
=================================

# cordic_arbiter

Shares one pipelined first-quadrant `cordic` core among `N_REQ` requesters. Each requester submits a full-circle angle over a valid/ready handshake. The block arbitrates round-robin and folds the angle into the first quadrant before driving the core. It carries the requester ID and quadrant alongside the core's fixed-latency pipeline, then unfolds the result and returns it to the issuing requester. It sits between the angle-producing clients (NCO, rotators) and the single `cordic` instance.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `D_WIDTH`, 11: core data width. The core takes a `D_WIDTH-1`-bit angle covering [0, π/2) and produces signed `D_WIDTH+1`-bit x/y scaled by 2^(D_WIDTH-1).
- `LAT`, `D_WIDTH-1` (10): core latency in cycles, from `cordic_z` sampled to `cordic_x`/`cordic_y` valid.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  issue enable. Low blocks new grants; in-flight results still complete.
- `req_valid`  in  N_REQ  per-requester request.
- `req_ready`  out  N_REQ  one-hot grant, or all zero.
- `req_angle`  in  N_REQ×(D_WIDTH+1)  packed angles; requester i uses slice i. LSB = π/2^D_WIDTH, so the full word spans [0, 2π).
- `rsp_valid`  out  N_REQ  single-cycle result strobe, at most one bit set. There is no backpressure on results.
- `rsp_x`, `rsp_y`  out  D_WIDTH+1 signed  unfolded cos/sin, shared by all requesters.
- `cordic_z`  out  D_WIDTH-1  angle to the core.
- `cordic_x`, `cordic_y`  in  D_WIDTH+1 signed  core outputs.

## Operation
- **Handshake:** a transfer occurs when `req_valid[i] && req_ready[i]`. Requester i holds `req_valid[i]` and `req_angle[i]` stable until the transfer. `req_ready` may depend combinationally on `req_valid`.
- **Arbitration:** round-robin with pointer `ptr`.
  - The grant goes to the first valid requester at or after `ptr`, modulo N_REQ.
  - On a grant to requester g, `ptr` becomes g+1 (wraps).
  - With no grant, `ptr` holds.
  - While `en`=0, `req_ready`=0 and `ptr` holds.
- **Fold:** the granted angle splits into `q` = top 2 bits and `a` = low `D_WIDTH-1` bits. `cordic_z` = `a` in the grant cycle, and 0 when there is no grant.
- **Tag pipeline:** `LAT` stages of {vld, id, q}. Stage 0 loads {1, g, q} on a grant and {0, x, x} otherwise. The pipeline shifts every cycle and never stalls.
- **Unfold:** applied when the last tag stage is valid, using c = `cordic_x`, s = `cordic_y`.
  - q=0: (c, s)
  - q=1: (−s, c)
  - q=2: (−c, −s)
  - q=3: (s, −c)
  - The result is registered into `rsp_x`/`rsp_y`, and `rsp_valid[id]` is set for one cycle.
- **Width:** negation is two's complement in D_WIDTH+1 bits. Core magnitude ≤ 2^(D_WIDTH-1), so there is no overflow.
- **Hold:** `rsp_x`/`rsp_y` hold their last value when `rsp_valid` is 0.

## Timing
- **Reset values:** `ptr`=0, all tag vld=0, `rsp_valid`=0, `rsp_x`=`rsp_y`=0, `cordic_z`=0.
- **Latency:** a handshake in cycle t produces `rsp_valid` high in cycle t+LAT+1 (11 at defaults).
- **Throughput:** one issue per cycle sustained, with no bubbles between requesters.
- **Ordering:** responses return in grant order, one per cycle at most.
- **Fairness:** with all N_REQ requesting continuously, each is granted exactly once in every N_REQ consecutive cycles.
- **Reset mid-operation:** all in-flight tags are discarded. No `rsp_valid` fires after reset release for pre-reset issues.
- **`en` falling:** already-issued requests still respond on schedule.
- **Wrap:** the angle word wraps naturally; angle 2^(D_WIDTH+1)−1 lies just below 2π.

## Structure
- **Package `cordic_pkg`:**
  - constants `D_WIDTH`, `LAT`;
  - typedef `quad_t` (2-bit);
  - typedef `tag_t` struct {vld, id, q};
  - function `unfold(q, c, s)`.
  - The core and this block share the package.
- **Sub-module `rr_arbiter`:** a parameterised round-robin arbiter holding `ptr`, with inputs `req`/`en` and a one-hot `gnt` output.
- The tag pipeline and unfold logic stay in `cordic_arbiter`.

## Test plan
1. **Single requester, quadrant 0:** req 0 issues angle 0 at cycle t → `rsp_valid`=4'b0001 at t+11, `rsp_x`=1024±51, `rsp_y`=0±51.
2. **Quadrant unfold:** angles 0x400, 0x800, 0xC00 from req 1 → (x, y) ≈ (0, 1024), (−1024, 0), (0, −1024), each within ±51.
3. **Contention:** all 4 requesters valid continuously for 40 cycles → grants cycle 0,1,2,3,0…; each requester gets 10 grants. Responses return in that order, 11 cycles after each grant.
4. **Throughput:** req 2 issues 100 back-to-back angles 0..99 → 100 consecutive `rsp_valid[2]` pulses, each matching the cos/sin model within tolerance.
5. **Enable gating:** `en`=0 with req 3 valid for 20 cycles → `req_ready`=0 throughout and `ptr` unchanged. `en`=1 → grant to req 3 in the same cycle.
6. **Reset mid-flight:** issue 5 requests, then pulse `rst_n` low 3 cycles later → all outputs zero immediately. No `rsp_valid` appears in the 20 cycles after release. The first grant after release goes to the lowest valid index starting from 0.

Source files
------------

// File: rtl/cordic_pkg.sv
// cordic_pkg
// Types and helpers shared by the first-quadrant cordic core and cordic_arbiter.
//   D_WIDTH : core data width; the core angle is D_WIDTH-1 bits and covers [0, pi/2)
//   LAT     : core latency in cycles, from cordic_z sampled to cordic_x/cordic_y valid
//   ID_W    : width of a requester ID (up to 8 requesters)
//   unfold  : maps a first-quadrant (cos, sin) pair back to the quadrant it came from
package cordic_pkg;

    localparam int D_WIDTH = 11;
    localparam int LAT     = D_WIDTH - 1;
    localparam int ID_W    = 3;

    typedef logic [1:0]                quad_t;
    typedef logic signed [D_WIDTH:0]   sample_t;

    // Side-band tag that travels next to the core pipeline.
    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
        quad_t           q;
    } tag_t;

    typedef struct packed {
        sample_t x;
        sample_t y;
    } xy_t;

    // Rotate (c, s) by q * pi/2. The core magnitude never exceeds 2^(D_WIDTH-1),
    // so negation in D_WIDTH+1 bits cannot overflow.
    function automatic xy_t unfold(input quad_t q, input sample_t c, input sample_t s);
        xy_t r;
        case (q)
            2'd0:    begin r.x = c;  r.y = s;  end
            2'd1:    begin r.x = -s; r.y = c;  end
            2'd2:    begin r.x = -c; r.y = -s; end
            default: begin r.x = s;  r.y = -c; end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cordic_arbiter_if.sv
// cordic_arbiter_if
// Request/response bus between the angle-producing clients and cordic_arbiter.
//   req_valid  : per-requester request
//   req_ready  : one-hot grant, or all zero
//   req_angle  : packed full-circle angles, requester i uses slice i (D_WIDTH+1 bits)
//   rsp_valid  : single-cycle result strobe, at most one bit set, no backpressure
//   rsp_x/y    : unfolded cos/sin shared by all requesters
// Modports: master = requesters, slave = cordic_arbiter.
interface cordic_arbiter_if
    import cordic_pkg::*;
#(
    parameter int N_REQ = 4
);

    logic [N_REQ-1:0]             req_valid;
    logic [N_REQ-1:0]             req_ready;
    logic [N_REQ*(D_WIDTH+1)-1:0] req_angle;
    logic [N_REQ-1:0]             rsp_valid;
    sample_t                      rsp_x;
    sample_t                      rsp_y;

    modport master (
        output req_valid, req_angle,
        input  req_ready, rsp_valid, rsp_x, rsp_y
    );

    modport slave (
        input  req_valid, req_angle,
        output req_ready, rsp_valid, rsp_x, rsp_y
    );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Round-robin arbiter. The grant goes to the first requester at or after ptr
// (modulo N); after a grant to g, ptr moves to g+1. With no grant, or while en
// is low, ptr holds.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : grant enable; low forces gnt to zero
//   req        : request vector
//   gnt        : one-hot grant (combinational from req), or all zero
//   idx        : binary index of the granted requester (valid when gnt != 0)
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);

    logic [PW-1:0] ptr;
    logic [PW-1:0] cand;
    logic          found;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block can leave a value stale and infer a latch.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                cand = PW'((int'(ptr) + k) % N);
                if (!found && req[cand]) begin
                    found     = 1'b1;
                    gnt[cand] = 1'b1;
                    idx       = cand;
                end
            end
        end
    end

    // NOTE: state is written with non-blocking assignments so every flop samples
    // the pre-edge values, independent of the order of always blocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/cordic_arbiter.sv
// cordic_arbiter
// Shares one pipelined first-quadrant cordic core among N_REQ requesters.
// A granted full-circle angle is split into quadrant q and first-quadrant angle
// a; a drives the core while {vld, id, q} travels through a LAT-stage tag
// pipeline alongside it. When the last tag is valid the core result is rotated
// back into quadrant q, registered, and strobed to the issuing requester.
//   clk, rst_n          : clock, asynchronous active-low reset
//   en                  : issue enable; in-flight results still complete when low
//   bus (slave)         : request/response bus, see cordic_arbiter_if
//   cordic_z            : first-quadrant angle to the core, 0 when nothing issues
//   cordic_x, cordic_y  : core outputs, valid LAT cycles after cordic_z is sampled
module cordic_arbiter
    import cordic_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    cordic_arbiter_if.slave     bus,
    output logic [D_WIDTH-2:0]  cordic_z,
    input  sample_t             cordic_x,
    input  sample_t             cordic_y
);

    localparam int AW = D_WIDTH + 1;

    logic [N_REQ-1:0] gnt;
    logic [PW-1:0]    gnt_idx;
    logic             granted;
    logic [AW-1:0]    angles [N_REQ];
    logic [AW-1:0]    sel_angle;
    tag_t             tag_in;
    tag_t             tags [LAT];
    tag_t             tag_out;
    xy_t              res;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .req   (bus.req_valid),
        .gnt   (gnt),
        .idx   (gnt_idx)
    );

    assign bus.req_ready = gnt;
    assign granted       = |gnt;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            angles[i] = bus.req_angle[i*AW +: AW];
        end
    end

    assign sel_angle = angles[gnt_idx];

    // Fold: top two bits select the quadrant, the rest is the in-quadrant angle.
    assign cordic_z = granted ? sel_angle[D_WIDTH-2:0] : '0;

    always_comb begin
        tag_in = '0;
        if (granted) begin
            tag_in.vld = 1'b1;
            tag_in.id  = ID_W'(gnt_idx);
            tag_in.q   = sel_angle[AW-1 -: 2];
        end
    end

    // The tag pipeline never stalls: it mirrors the core's fixed latency.
    // NOTE: only vld strictly needs a reset, but the pipeline is a handful of
    // flops, so the whole tag is cleared to keep reset behaviour uniform.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                tags[i] <= '0;
            end
        end else begin
            tags[0] <= tag_in;
            for (int i = 1; i < LAT; i++) begin
                tags[i] <= tags[i-1];
            end
        end
    end

    assign tag_out = tags[LAT-1];
    assign res     = unfold(tag_out.q, cordic_x, cordic_y);

    // Results hold between strobes; rsp_valid is a one-cycle pulse on the issuer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_valid <= '0;
            bus.rsp_x     <= '0;
            bus.rsp_y     <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                bus.rsp_valid[i] <= tag_out.vld && (tag_out.id == ID_W'(i));
            end
            if (tag_out.vld) begin
                bus.rsp_x <= res.x;
                bus.rsp_y <= res.y;
            end
        end
    end

endmodule

// File: tb/tb_cordic_arbiter.sv
// tb_cordic_arbiter
// Bench for cordic_arbiter with four requesters. A behavioural cordic core
// (rounded cos/sin of the first-quadrant angle, LAT-cycle delay line) feeds the
// DUT. Expected results come from cos/sin of the full-circle angle, grants from
// a round-robin pointer kept in the bench, and response timing from a queue of
// due cycles.
module tb_cordic_arbiter;
    import cordic_pkg::*;

    localparam int  N   = 4;
    localparam int  AW  = D_WIDTH + 1;
    localparam int  TOL = 2;
    localparam real PI  = 3.14159265358979;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                en;
    logic [D_WIDTH-2:0]  cordic_z;
    sample_t             cordic_x;
    sample_t             cordic_y;

    cordic_arbiter_if #(.N_REQ(N)) bus ();

    cordic_arbiter #(.N_REQ(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .bus      (bus),
        .cordic_z (cordic_z),
        .cordic_x (cordic_x),
        .cordic_y (cordic_y)
    );

    always #5 clk = ~clk;

    function automatic int rnd(input real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(-v + 0.5);
    endfunction

    // One LSB is pi/2048 for both the core angle and the full-circle angle.
    function automatic int ref_cos(input int a);
        return rnd(1024.0 * $cos($itor(a) * PI / 2048.0));
    endfunction

    function automatic int ref_sin(input int a);
        return rnd(1024.0 * $sin($itor(a) * PI / 2048.0));
    endfunction

    // Behavioural first-quadrant core.
    sample_t cx_pipe [LAT];
    sample_t cy_pipe [LAT];

    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) begin
            cx_pipe[i] <= cx_pipe[i-1];
            cy_pipe[i] <= cy_pipe[i-1];
        end
        cx_pipe[0] <= sample_t'(ref_cos(int'(cordic_z)));
        cy_pipe[0] <= sample_t'(ref_sin(int'(cordic_z)));
    end

    assign cordic_x = cx_pipe[LAT-1];
    assign cordic_y = cy_pipe[LAT-1];

    // Per-requester sources: angles waiting to be transferred.
    logic [AW-1:0] src_mem [N][256];
    int            src_rd [N];
    int            src_wr [N];

    typedef struct {
        int id;
        int due;
        int ex;
        int ey;
    } exp_t;

    exp_t exp_q [$];
    int   mptr;
    int   cycle;
    int   grants [N];
    int   last_x;
    int   last_y;
    int   n_cmp;
    int   n_bad;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, want, cycle);
        end
    endtask

    task automatic check_near(input string tag, input logic signed [31:0] obs,
                              input int want);
        logic signed [31:0] d;
        n_cmp++;
        d = obs - want;
        assert (((d <= TOL) && (d >= -TOL)) === 1'b1) else begin
            n_bad++;
            $error("FAIL %s: got %0d want %0d+-%0d (cycle %0d)", tag, obs, want, TOL, cycle);
        end
    endtask

    task automatic push(input int r, input int a);
        src_mem[r][src_wr[r]] = AW'(a);
        src_wr[r]++;
    endtask

    // One clock cycle: drive, check against the model, advance the model.
    // Entered and left just after a falling edge.
    task automatic tick();
        int   g;
        int   a;
        exp_t e;
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]         = (src_rd[i] < src_wr[i]);
            bus.req_angle[i*AW +: AW] = src_mem[i][src_rd[i]];
        end
        #1;
        g = -1;
        if (en && rst_n) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && src_rd[(mptr + k) % N] < src_wr[(mptr + k) % N]) g = (mptr + k) % N;
            end
        end
        check("req_ready", bus.req_ready, (g >= 0) ? (1 << g) : 0);
        a = (g >= 0) ? int'(src_mem[g][src_rd[g]]) : 0;
        check("cordic_z", cordic_z, a % 1024);

        if (exp_q.size() > 0 && exp_q[0].due == cycle) begin
            e = exp_q.pop_front();
            check("rsp_valid", bus.rsp_valid, 1 << e.id);
            check_near("rsp_x", bus.rsp_x, e.ex);
            check_near("rsp_y", bus.rsp_y, e.ey);
            last_x = e.ex;
            last_y = e.ey;
        end else begin
            check("rsp_valid idle", bus.rsp_valid, 0);
            check_near("rsp_x hold", bus.rsp_x, last_x);
            check_near("rsp_y hold", bus.rsp_y, last_y);
        end

        if (g >= 0) begin
            exp_q.push_back('{g, cycle + LAT + 1, ref_cos(a), ref_sin(a)});
            mptr = (g + 1) % N;
            grants[g]++;
            src_rd[g]++;
        end
        @(posedge clk);
        cycle++;
        @(negedge clk);
    endtask

    function automatic bit busy();
        for (int i = 0; i < N; i++) if (src_rd[i] < src_wr[i]) return 1'b1;
        return exp_q.size() > 0;
    endfunction

    // Run until all sources and expected responses are consumed, bounded.
    task automatic drain(input string tag);
        for (int k = 0; k < 400 && busy(); k++) tick();
        check({tag, " drained"}, busy(), 0);
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        cycle  = 0;
        mptr   = 0;
        last_x = 0;
        last_y = 0;
        for (int i = 0; i < N; i++) begin
            src_rd[i] = 0;
            src_wr[i] = 0;
            grants[i] = 0;
            for (int j = 0; j < 256; j++) src_mem[i][j] = '0;
        end
        rst_n         = 1'b0;
        en            = 1'b1;
        bus.req_valid = '0;
        bus.req_angle = '0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("reset rsp_valid", bus.rsp_valid, 0);
        check("reset rsp_x", bus.rsp_x, 0);
        check("reset rsp_y", bus.rsp_y, 0);
        check("reset cordic_z", cordic_z, 0);
        check("reset req_ready", bus.req_ready, 0);
        rst_n = 1'b1;
        tick();

        // Single requester, quadrant 0.
        push(0, 0);
        drain("single");

        // Quadrant unfold from requester 1, including the wrap edge below 2*pi.
        push(1, 'h400);
        push(1, 'h800);
        push(1, 'hC00);
        push(1, 'hFFF);
        push(1, 'h3FF);
        drain("quadrant");

        // Contention: all four requesting continuously for 40 grants.
        for (int i = 0; i < N; i++) begin
            grants[i] = 0;
            for (int j = 0; j < 10; j++) push(i, int'($urandom_range(0, 4095)));
        end
        drain("contention");
        for (int i = 0; i < N; i++) check($sformatf("grants[%0d]", i), grants[i], 10);

        // Throughput: 100 back-to-back angles from requester 2.
        grants[2] = 0;
        for (int j = 0; j < 100; j++) push(2, j);
        drain("throughput");
        check("throughput grants", grants[2], 100);

        // Enable gating: no grant while en is low, grant in the cycle en rises.
        en = 1'b0;
        push(3, int'($urandom_range(0, 4095)));
        repeat (20) tick();
        check("gated grants", src_rd[3] < src_wr[3], 1);
        en = 1'b1;
        tick();
        check("grant on enable", src_rd[3] == src_wr[3], 1);
        drain("enable");

        // Reset mid-flight: five issues, then reset three cycles later.
        for (int j = 0; j < 5; j++) push(0, int'($urandom_range(0, 4095)));
        repeat (8) tick();
        rst_n = 1'b0;
        #1;
        check("midrst rsp_valid", bus.rsp_valid, 0);
        check("midrst rsp_x", bus.rsp_x, 0);
        check("midrst rsp_y", bus.rsp_y, 0);
        check("midrst cordic_z", cordic_z, 0);
        check("midrst req_ready", bus.req_ready, 0);
        exp_q.delete();
        mptr   = 0;
        last_x = 0;
        last_y = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        push(0, int'($urandom_range(0, 4095)));
        push(2, int'($urandom_range(0, 4095)));
        tick();
        check("post-reset first grant", src_rd[0], src_wr[0]);
        drain("post-reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
